// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command path: command codes and sequencer state encoding.
// Used by lcd_cmd_seq and by the LCD controller bench.
package lcd_pkg;

  localparam logic [3:0] CMD_WRITE       = 4'd0;
  localparam logic [3:0] CMD_SHIFT_UP    = 4'd1;
  localparam logic [3:0] CMD_SHIFT_DOWN  = 4'd2;
  localparam logic [3:0] CMD_SHIFT_LEFT  = 4'd3;
  localparam logic [3:0] CMD_SHIFT_RIGHT = 4'd4;
  localparam logic [3:0] CMD_MAX         = 4'd5;
  localparam logic [3:0] CMD_MIN         = 4'd6;
  localparam logic [3:0] CMD_AVG         = 4'd7;
  localparam logic [3:0] CMD_ROT_CCW     = 4'd8;
  localparam logic [3:0] CMD_ROT_CW      = 4'd9;
  localparam logic [3:0] CMD_MIRROR_X    = 4'd10;
  localparam logic [3:0] CMD_MIRROR_Y    = 4'd11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    HOLD      = 3'd2,
    WAIT_DONE = 3'd3,
    FINISHED  = 3'd4
  } state_t;

  // Codes above the last defined command are rejected by the sequencer.
  function automatic logic is_illegal(input logic [3:0] code);
    return code > CMD_MIRROR_Y;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small command buffer: 4-bit entries, pointers carry an extra wrap bit so that
// full and empty are told apart. Head entry is readable combinationally.
module cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic [3:0] wdata_i,
  input  logic       pop_i,
  output logic [3:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [3:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/lcd_cmd_seq.sv
// Host-to-LCD-controller command sequencer: buffers legal commands and issues
// them one at a time, waiting for the controller to go idle between issues.
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] host_cmd,
  input  logic       host_valid,
  output logic       host_ready,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  input  logic       busy,
  input  logic       done,
  output logic       seq_done,
  output logic       err_illegal,
  output logic [7:0] issued_cnt
);
  state_t     state_q, state_d;
  logic       write_seen_q, write_seen_d;
  logic [3:0] cmd_q, cmd_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       seq_done_q, seq_done_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;

  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [3:0] fifo_rdata;
  logic       xfer, illegal;

  assign host_ready = !reset && !fifo_full && !write_seen_q && (state_q != FINISHED);
  assign xfer       = host_valid && host_ready;
  assign illegal    = is_illegal(host_cmd);
  assign fifo_push  = xfer && !illegal;

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (host_cmd),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    fifo_pop     = 1'b0;
    write_seen_d = write_seen_q || (fifo_push && host_cmd == CMD_WRITE);
    err_d        = err_q || (xfer && illegal);
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !busy) begin
          fifo_pop = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = (cmd_q == CMD_WRITE) ? WAIT_DONE : HOLD;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
      // The controller may not raise busy until after our strobe, so stay here
      // at least one cycle before trusting busy == 0.
      HOLD:      if (!busy) state_d = IDLE;
      WAIT_DONE: if (done) state_d = FINISHED;
      FINISHED:  state_d = FINISHED;
      default:   state_d = IDLE;
    endcase
    cmd_d       = fifo_pop ? fifo_rdata : cmd_q;
    cmd_valid_d = (state_d == ISSUE);
    seq_done_d  = (state_d == FINISHED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      write_seen_q <= 1'b0;
      cmd_q        <= '0;
      cmd_valid_q  <= 1'b0;
      seq_done_q   <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      write_seen_q <= write_seen_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      seq_done_q   <= seq_done_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign cmd         = cmd_q;
  assign cmd_valid   = cmd_valid_q;
  assign seq_done    = seq_done_q;
  assign err_illegal = err_q;
  assign issued_cnt  = cnt_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed bench for lcd_cmd_seq: inputs change on the falling edge, outputs are
// checked 1 ns later; a monitor logs every cmd_valid pulse with its cycle number.
module tb_lcd_cmd_seq;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] host_cmd = 4'd0;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done = 1'b0;
  logic       seq_done;
  logic       err_illegal;
  logic [7:0] issued_cnt;

  logic       busy_mode = 1'b0;   // 0: busy_man drives busy; 1: busy follows cmd_valid by one cycle
  logic       busy_man = 1'b0;
  logic       busy_pipe = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] log_cmd[$];
  int         log_cyc[$];

  always #5 clk = ~clk;

  assign busy = busy_mode ? busy_pipe : busy_man;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    busy_pipe <= cmd_valid;
  end

  always @(negedge clk) begin
    if (cmd_valid) begin
      log_cmd.push_back(cmd);
      log_cyc.push_back(cyc);
    end
  end

  lcd_cmd_seq #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .host_cmd    (host_cmd),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .busy        (busy),
    .done        (done),
    .seq_done    (seq_done),
    .err_illegal (err_illegal),
    .issued_cnt  (issued_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    host_valid = 1'b0;
    done       = 1'b0;
    busy_mode  = 1'b0;
    busy_man   = 1'b0;
    reset      = 1'b1;
    #1;
    chk("rst_host_ready", host_ready, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    tick(2);
    log_cmd.delete();
    log_cyc.delete();
    reset = 1'b0;
    #1;
    chk("rel_host_ready", host_ready, 1);
  endtask

  // Offers one code for one cycle; reports host_ready as seen during that cycle.
  task automatic offer(input logic [3:0] c, output logic rdy);
    host_cmd   = c;
    host_valid = 1'b1;
    #1;
    rdy = host_ready;
    tick(1);
    host_valid = 1'b0;
  endtask

  initial begin
    logic rdy;
    int   n0;
    bit   got;

    tick(1);
    do_reset();
    chk("rst_cmd", cmd, 0);
    chk("rst_seq_done", seq_done, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_cnt", issued_cnt, 0);

    // Latency: push 2 in cycle N -> single strobe in cycle N+2
    n0 = cyc;
    offer(4'd2, rdy);
    chk("lat_ready", rdy, 1);
    tick(10);
    chk("lat_pulses", log_cmd.size(), 1);
    if (log_cmd.size() >= 1) begin
      chk("lat_cmd", log_cmd[0], 2);
      chk("lat_cycle", log_cyc[0], n0 + 2);
    end
    chk("lat_cnt", issued_cnt, 1);
    chk("lat_cmd_hold", cmd, 2);

    // Illegal code: accepted, flagged, never issued
    do_reset();
    offer(4'd13, rdy);
    chk("ill_ready", rdy, 1);
    #1;
    chk("ill_err", err_illegal, 1);
    tick(6);
    chk("ill_pulses", log_cmd.size(), 0);
    chk("ill_cnt", issued_cnt, 0);

    // 1,5,0 with busy following each strobe, then done
    do_reset();
    busy_mode = 1'b1;
    offer(4'd1, rdy); chk("seq_rdy1", rdy, 1);
    offer(4'd5, rdy); chk("seq_rdy5", rdy, 1);
    offer(4'd0, rdy); chk("seq_rdy0", rdy, 1);
    tick(25);
    chk("seq_pulses", log_cmd.size(), 3);
    if (log_cmd.size() == 3) begin
      chk("seq_cmd0", log_cmd[0], 1);
      chk("seq_cmd1", log_cmd[1], 5);
      chk("seq_cmd2", log_cmd[2], 0);
    end
    chk("seq_not_done", seq_done, 0);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    #1;
    chk("seq_done", seq_done, 1);
    chk("seq_cnt", issued_cnt, 3);
    chk("seq_ready_fin", host_ready, 0);

    // Back-to-back with busy held: four accepts, fifth waits until drain starts
    do_reset();
    busy_man = 1'b1;
    offer(4'd1, rdy); chk("full_rdy1", rdy, 1);
    offer(4'd2, rdy); chk("full_rdy2", rdy, 1);
    offer(4'd3, rdy); chk("full_rdy3", rdy, 1);
    offer(4'd4, rdy); chk("full_rdy4", rdy, 1);
    offer(4'd6, rdy); chk("full_rdy5", rdy, 0);
    offer(4'd6, rdy); chk("full_rdy5b", rdy, 0);
    chk("full_no_issue", log_cmd.size(), 0);
    busy_man = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      offer(4'd6, rdy);
      got = rdy;
    end
    chk("full_fifth_accepted", got, 1);
    tick(40);
    chk("full_pulses", log_cmd.size(), 5);
    if (log_cmd.size() == 5) begin
      chk("full_cmd0", log_cmd[0], 1);
      chk("full_cmd1", log_cmd[1], 2);
      chk("full_cmd2", log_cmd[2], 3);
      chk("full_cmd3", log_cmd[3], 4);
      chk("full_cmd4", log_cmd[4], 6);
    end
    chk("full_cnt", issued_cnt, 5);

    // Write then another offer: refused; only write issued; finish after done
    do_reset();
    offer(4'd0, rdy); chk("wr_rdy0", rdy, 1);
    offer(4'd3, rdy); chk("wr_rdy3", rdy, 0);
    offer(4'd3, rdy); chk("wr_rdy3b", rdy, 0);
    tick(8);
    chk("wr_pulses", log_cmd.size(), 1);
    if (log_cmd.size() == 1) chk("wr_cmd", log_cmd[0], 0);
    chk("wr_not_done", seq_done, 0);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    tick(4);
    chk("wr_done", seq_done, 1);
    chk("wr_pulses_after", log_cmd.size(), 1);
    chk("wr_cnt", issued_cnt, 1);

    // Reset with three commands queued behind a busy controller
    do_reset();
    busy_man = 1'b1;
    offer(4'd1, rdy);
    offer(4'd2, rdy);
    offer(4'd3, rdy);
    chk("mid_queued_none", log_cmd.size(), 0);
    do_reset();
    chk("mid_cmd", cmd, 0);
    chk("mid_cmd_valid", cmd_valid, 0);
    chk("mid_seq_done", seq_done, 0);
    chk("mid_err", err_illegal, 0);
    chk("mid_cnt", issued_cnt, 0);
    tick(12);
    chk("mid_no_pulses", log_cmd.size(), 0);
    chk("mid_ready", host_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
